plantard_premul: RTL and testbench
==================================

PLANTARD_PREMUL -- requirements
Module: plantard_premul

Interface
REQ-001 The block SHALL have parameter W, default 32, giving the modulus width; the output width is 2W.
REQ-002 The block SHALL have parameter Q, default 3329, giving the odd modulus.
REQ-003 The block SHALL have parameter QINV, default Q^-1 mod 2^(2W), giving the Plantard constant.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the operand pair this cycle.
REQ-008 The block SHALL have port a, input, W bits: signed multiplicand.
REQ-009 The block SHALL have port b, input, W bits: signed multiplier.
REQ-010 The block SHALL have port out_valid, output, 1 bit: A_out is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream Plantard reducer accepts A_out.
REQ-012 The block SHALL have port A_out, output, 2W bits, signed: premultiplied product fed to the reducer's A input.

Function
REQ-013 The block SHALL compute A_out = a * (b * QINV mod 2^(2W)) mod 2^(2W), with a and b sign-extended to 2W bits before multiplication and every product truncated to its low 2W bits.
REQ-014 Stage 1 SHALL register a and bq = (b * QINV) mod 2^(2W), together with valid flag v1.
REQ-015 Stage 2 SHALL register A_out = (a1 * bq1) mod 2^(2W), with its valid flag driving out_valid.
REQ-016 Latency SHALL be exactly 2 cycles from an accepted input to out_valid with zero backpressure; throughput SHALL be 1 result per cycle.
REQ-017 The block SHALL define advance = !out_valid || out_ready, and in_ready SHALL equal advance, combinationally.
REQ-018 On advance, stage 1 SHALL load {in_valid, a, bq}, and stage 2 SHALL load {v1, a1*bq1}; when advance is low, all pipeline registers SHALL hold.
REQ-019 An input SHALL be accepted only when in_valid && in_ready; when in_valid is low during advance, a bubble (v1=0) SHALL enter and the data registers MAY update freely.
REQ-020 While out_valid && !out_ready, A_out SHALL remain stable and no result SHALL be lost or duplicated.
REQ-021 When out_ready rises while out_valid is set and in_valid is set in the same cycle, the output SHALL be consumed and the new operand accepted in that cycle.
REQ-022 A result SHALL be held while out_ready is low indefinitely, and the pipeline SHALL resume without reordering.

Reset
REQ-023 Assertion of rst_n low SHALL immediately clear v1, out_valid, and all data registers, including A_out = 0, independent of clk.
REQ-024 A reset mid-operation SHALL discard in-flight results, and the first output after deassertion SHALL come from an input accepted after deassertion.
REQ-025 in_ready SHALL read 1 during and after reset, since out_valid is 0.

Configuration
REQ-026 Macro PLANTARD_PREMUL_PRECOMP_EN, when defined, SHALL add inputs b_pre (2W bits) and pre_sel (1 bit).
REQ-027 With PLANTARD_PREMUL_PRECOMP_EN defined and pre_sel=1 on an accepted input, stage 1 SHALL load bq = b_pre, bypassing the QINV multiply (precomputed twiddle); latency SHALL be unchanged.
REQ-028 Without PLANTARD_PREMUL_PRECOMP_EN, the ports b_pre and pre_sel SHALL be absent, and bq SHALL always be computed from b.

Structure
REQ-029 Package plantard_pkg SHALL hold W, Q, QINV, and the 2W-bit signed product typedef, shared with the Plantard reducer.
REQ-030 The block SHALL contain sub-module mul_trunc2w (2W x 2W -> low 2W, combinational), instantiated twice: once for b*QINV and once for a1*bq1.

Verification
REQ-031 A bench SHALL drive a=1, b=Q with out_ready=1 and SHALL check that A_out = 1 with out_valid exactly 2 cycles after acceptance.
REQ-032 A bench SHALL drive a=1, b=1 and SHALL check A_out = QINV, and SHALL drive a=-1 (all ones), b=1 and SHALL check A_out = 2^(2W) - QINV.
REQ-033 A bench SHALL stream 16 random pairs back-to-back with out_ready=1 and SHALL check one result per cycle, in order, each matching the reference model feeding the Plantard reducer, with the final T = a*b*(-2^(-2W)) mod Q.
REQ-034 A bench SHALL hold out_ready=0 for 5 cycles with 3 inputs offered and SHALL check that in_ready drops once out_valid is set, A_out is stable, and after release results emerge in order with none lost.
REQ-035 A bench SHALL pull rst_n low with 2 results in flight and SHALL check out_valid=0 and A_out=0 immediately, and that no stale result appears after release.
REQ-036 With PLANTARD_PREMUL_PRECOMP_EN defined, a bench SHALL drive pre_sel=1, b_pre=1, a=7 and SHALL check A_out = 7.

Source files
------------

// File: rtl/plantard_pkg.sv
// Shared constants and types for the Plantard multiply/reduce datapath.
// The premultiplier and the downstream Plantard reducer both import this
// package, so the modulus, its width and the Plantard constant live in
// one place.
package plantard_pkg;

  // Inverse of an odd value modulo 2^128 by Newton iteration.
  // Any odd q satisfies q*q == 1 mod 8, so q itself is a 3-bit-correct seed.
  // Each step doubles the number of correct bits: 3,6,12,24,48,96,192.
  // Seven steps therefore cover 128 bits. Callers keep the low 2W bits.
  function automatic logic [127:0] plantard_qinv(input logic [127:0] q);
    logic [127:0] x;
    x = q;
    for (int i = 0; i < 7; i++) begin
      x = x * (128'd2 - q * x);
    end
    return x;
  endfunction

  localparam int          PLANTARD_W    = 32;
  localparam int unsigned PLANTARD_Q    = 3329;
  localparam logic [2*PLANTARD_W-1:0] PLANTARD_QINV =
    (2*PLANTARD_W)'(plantard_qinv(128'(PLANTARD_Q)));

  // Signed 2W-bit product: the A operand handed to the Plantard reducer.
  typedef logic signed [2*PLANTARD_W-1:0] plantard_prod_t;

endpackage

// File: rtl/mul_trunc2w.sv
// Combinational N x N multiply that keeps only the low N bits of the product.
// The low N bits are identical for signed and unsigned operands, so callers
// pass two's-complement values as they are.
module mul_trunc2w
  import plantard_pkg::*;
#(
  parameter int N = 2 * PLANTARD_W
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] p
);

  // The assignment context is N bits wide, so the upper half of the
  // product is never formed.
  assign p = x * y;

endmodule

// File: rtl/plantard_premul.sv
// Two-stage premultiplier for Plantard modular multiplication.
//   stage 1 : a1  <= sext(a),  bq1 <= sext(b) * QINV  (mod 2^(2W))
//   stage 2 : A   <= a1 * bq1                          (mod 2^(2W))
// The pipeline uses valid/ready handshakes. It advances as a whole whenever
// the output slot is empty or is being consumed.
// Optional build macro PLANTARD_PREMUL_PRECOMP_EN adds the b_pre and pre_sel
// inputs. With pre_sel=1, a precomputed b*QINV (a twiddle) is loaded directly
// and the first multiply is skipped.
module plantard_premul
  import plantard_pkg::*;
#(
  parameter int              W    = PLANTARD_W,
  parameter int unsigned     Q    = PLANTARD_Q,
  parameter logic [2*W-1:0]  QINV = (2*W)'(plantard_qinv(128'(Q)))
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
`ifdef PLANTARD_PREMUL_PRECOMP_EN
  input  logic [2*W-1:0]        b_pre,
  input  logic                  pre_sel,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*W-1:0] A_out
);

  localparam int N = 2 * W;

  logic         advance;
  logic [N-1:0] a_ext;
  logic [N-1:0] b_ext;
  logic [N-1:0] bq_mul;
  logic [N-1:0] bq1_next;
  logic [N-1:0] prod;

  logic         v1_reg;
  logic [N-1:0] a1_reg;
  logic [N-1:0] bq1_reg;
  logic         out_valid_reg;
  logic [N-1:0] a_out_reg;

  // Every stage moves together. A full output slot that is not consumed
  // freezes the whole pipe, so nothing is overwritten or lost.
  assign advance  = !out_valid_reg || out_ready;
  assign in_ready = advance;

  assign a_ext = {{W{a[W-1]}}, a};
  assign b_ext = {{W{b[W-1]}}, b};

  mul_trunc2w #(.N(N)) u_mul_bq (
    .x (b_ext),
    .y (QINV),
    .p (bq_mul)
  );

`ifdef PLANTARD_PREMUL_PRECOMP_EN
  // A precomputed twiddle already carries the QINV factor.
  assign bq1_next = pre_sel ? b_pre : bq_mul;
`else
  assign bq1_next = bq_mul;
`endif

  mul_trunc2w #(.N(N)) u_mul_prod (
    .x (a1_reg),
    .y (bq1_reg),
    .p (prod)
  );

  // Valid flags: a bubble enters stage 1 whenever in_valid is low during advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (advance) begin
      v1_reg        <= in_valid;
      out_valid_reg <= v1_reg;
    end
  end

  // Data registers: the stage contents behind bubbles are don't-care, but
  // they hold while the pipe is stalled so that A_out stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_reg    <= '0;
      bq1_reg   <= '0;
      a_out_reg <= '0;
    end else if (advance) begin
      a1_reg    <= a_ext;
      bq1_reg   <= bq1_next;
      a_out_reg <= prod;
    end
  end

  assign out_valid = out_valid_reg;
  assign A_out     = a_out_reg;

endmodule

// File: tb/tb_plantard_premul.sv
// Self-checking bench for plantard_premul (default W=32, Q=3329).
// Expected values come from a plain-arithmetic model, A = a*b*QINV mod 2^64.
// QINV is derived here with a bitwise lifting loop.
// Results are also pushed through an exact Plantard reduction. That confirms
// T == a*b*(-2^-64) mod Q.
// Define PLANTARD_PREMUL_PRECOMP_EN to exercise the precomputed-twiddle path.
`timescale 1ns/1ps
module tb_plantard_premul;

  localparam int          W  = 32;
  localparam int          N  = 64;
  localparam int unsigned QM = 3329;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [W-1:0]          a = '0;
  logic [W-1:0]          b = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic signed [N-1:0]   A_out;
`ifdef PLANTARD_PREMUL_PRECOMP_EN
  logic [N-1:0]          b_pre = '0;
  logic                  pre_sel = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] qinv_tb;
  int          negr;      // -2^-64 mod Q

  plantard_premul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef PLANTARD_PREMUL_PRECOMP_EN
    .b_pre     (b_pre),
    .pre_sel   (pre_sel),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A_out     (A_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Q^-1 mod 2^64, lifted one bit at a time.
  function automatic logic [63:0] calc_qinv();
    logic [63:0] x;
    logic [63:0] q;
    logic [63:0] p;
    q = 64'(QM);
    x = 64'd1;
    for (int i = 1; i < 64; i++) begin
      p = q * x;
      if (p[i]) x[i] = 1'b1;
    end
    return x;
  endfunction

  // Model: product of the signed operands times QINV, wrapped to 64 bits.
  function automatic logic [63:0] model_a(input logic [31:0] x, input logic [31:0] y);
    longint xs;
    longint ys;
    logic [63:0] p;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    p  = xs * ys;
    return p * qinv_tb;
  endfunction

  // Exact Plantard reduction of A: (A*Q - a*b) / 2^64, reduced mod Q.
  function automatic int plantard_t(input logic [63:0] av, input logic [31:0] x, input logic [31:0] y);
    logic signed [127:0] aw;
    logic signed [127:0] abw;
    logic signed [127:0] qw;
    logic signed [127:0] t;
    longint ab;
    ab  = longint'($signed(x)) * longint'($signed(y));
    aw  = {{64{av[63]}}, av};
    abw = ab;
    qw  = 128'(QM);
    t   = (aw * qw - abw) >>> 64;
    t   = t % qw;
    if (t < 0) t = t + qw;
    return int'(t);
  endfunction

  // Reference value of a*b*(-2^-64) mod Q.
  function automatic int expected_t(input logic [31:0] x, input logic [31:0] y);
    longint ab;
    longint m;
    ab = longint'($signed(x)) * longint'($signed(y));
    m  = ab % longint'(QM);
    if (m < 0) m = m + longint'(QM);
    return int'((m * longint'(negr)) % longint'(QM));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    vectors++;
    if (A_out !== 64'd0) begin miscompares++; $display("FAIL reset_a_out: got %h want 0", A_out); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_identity();
    a = 32'd1; b = QM; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL identity_accept: in_ready=%0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL identity_latency1: out_valid=%0b want 0", out_valid); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || A_out !== 64'd1) begin
      miscompares++;
      $display("FAIL identity_result: out_valid=%0b A_out=%h want 1/%h", out_valid, A_out, 64'd1);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL identity_no_dup: out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_qinv();
    logic [63:0] neg_qinv;
    neg_qinv = 64'd0 - qinv_tb;
    out_ready = 1'b1;
    a = 32'd1; b = 32'd1; in_valid = 1'b1;
    tick();
    a = 32'hFFFF_FFFF; b = 32'd1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || A_out !== qinv_tb) begin
      miscompares++;
      $display("FAIL qinv_pos: out_valid=%0b A_out=%h want 1/%h", out_valid, A_out, qinv_tb);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || A_out !== neg_qinv) begin
      miscompares++;
      $display("FAIL qinv_neg: out_valid=%0b A_out=%h want 1/%h", out_valid, A_out, neg_qinv);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa [16];
    logic [31:0] pb [16];
    logic [63:0] e;
    int t_obs;
    int t_exp;
    for (int i = 0; i < 16; i++) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 16) begin
        in_valid = 1'b1; a = pa[cyc]; b = pb[cyc];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc < 16) begin
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready cyc%0d: got %0b want 1", cyc, in_ready); end
      end
      if (cyc >= 2 && cyc < 18) begin
        e = model_a(pa[cyc-2], pb[cyc-2]);
        vectors++;
        if (out_valid !== 1'b1 || A_out !== e) begin
          miscompares++;
          $display("FAIL b2b_result #%0d: out_valid=%0b A_out=%h want 1/%h", cyc-2, out_valid, A_out, e);
        end
        t_obs = plantard_t(A_out, pa[cyc-2], pb[cyc-2]);
        t_exp = expected_t(pa[cyc-2], pb[cyc-2]);
        vectors++;
        if (t_obs != t_exp) begin
          miscompares++;
          $display("FAIL b2b_plantard_t #%0d: got %0d want %0d", cyc-2, t_obs, t_exp);
        end
      end else begin
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle cyc%0d: out_valid=%0b want 0", cyc, out_valid); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] expq [$];
    logic [63:0] e;
    logic [63:0] prev_a;
    logic        prev_stall;
    logic        acc;
    int sent;
    int got;
    sent = 0; got = 0; prev_stall = 1'b0; prev_a = '0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      if (!in_valid && sent < 3) begin
        in_valid = 1'b1; a = $urandom; b = $urandom;
      end
      out_ready = (cyc >= 5);
      acc = 1'b0;
      @(negedge clk);
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || A_out !== prev_a) begin
          miscompares++;
          $display("FAIL bp_stable cyc%0d: out_valid=%0b A_out=%h want 1/%h", cyc, out_valid, A_out, prev_a);
        end
      end
      if (out_valid && !out_ready) begin
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cyc%0d: got %0b want 0", cyc, in_ready); end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra cyc%0d: A_out=%h with no result pending", cyc, A_out);
        end else begin
          e = expq.pop_front();
          if (A_out !== e) begin miscompares++; $display("FAIL bp_result #%0d: got %h want %h", got, A_out, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model_a(a, b));
        sent++;
        acc = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_a     = A_out;
      tick();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    vectors++;
    if (got != 3) begin miscompares++; $display("FAIL bp_count: got %0d results want 3", got); end
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_random_flow();
    logic [63:0] expq [$];
    logic [63:0] e;
    logic [63:0] prev_a;
    logic        prev_stall;
    logic        acc;
    int sent;
    int got;
    sent = 0; got = 0; prev_stall = 1'b0; prev_a = '0;
    for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
      if (!in_valid && sent < 40 && $urandom_range(3) != 0) begin
        in_valid = 1'b1; a = $urandom; b = $urandom;
      end
      out_ready = ($urandom_range(2) != 0);
      acc = 1'b0;
      @(negedge clk);
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || A_out !== prev_a) begin
          miscompares++;
          $display("FAIL flow_stable cyc%0d: out_valid=%0b A_out=%h want 1/%h", cyc, out_valid, A_out, prev_a);
        end
      end
      vectors++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        miscompares++;
        $display("FAIL flow_in_ready cyc%0d: got %0b want %0b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL flow_extra cyc%0d: A_out=%h with no result pending", cyc, A_out);
        end else begin
          e = expq.pop_front();
          if (A_out !== e) begin miscompares++; $display("FAIL flow_result #%0d: got %h want %h", got, A_out, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model_a(a, b));
        sent++;
        acc = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_a     = A_out;
      tick();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    vectors++;
    if (got != 40) begin miscompares++; $display("FAIL flow_count: got %0d results want 40", got); end
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset_midflight();
    logic [63:0] e;
    out_ready = 1'b0;
    in_valid = 1'b1; a = $urandom; b = $urandom;
    tick();
    a = $urandom; b = $urandom;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_inflight: out_valid=%0b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || A_out !== 64'd0) begin
      miscompares++;
      $display("FAIL midrst_clear: out_valid=%0b A_out=%h want 0/0", out_valid, A_out);
    end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_stale cyc%0d: out_valid=%0b want 0", i, out_valid); end
    end
    in_valid = 1'b1; a = $urandom; b = $urandom;
    e = model_a(a, b);
    tick();
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || A_out !== e) begin
      miscompares++;
      $display("FAIL midrst_fresh: out_valid=%0b A_out=%h want 1/%h", out_valid, A_out, e);
    end
    tick();
  endtask

`ifdef PLANTARD_PREMUL_PRECOMP_EN
  task automatic test_precomp();
    logic [63:0] r;
    logic [63:0] e;
    out_ready = 1'b1;
    a = 32'd7; b = $urandom; b_pre = 64'd1; pre_sel = 1'b1; in_valid = 1'b1;
    tick();
    r = {$urandom, $urandom};
    a = $urandom; b = $urandom; b_pre = r;
    e = {{32{a[31]}}, a} * r;
    tick();
    in_valid = 1'b0; pre_sel = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || A_out !== 64'd7) begin
      miscompares++;
      $display("FAIL precomp_seven: out_valid=%0b A_out=%h want 1/%h", out_valid, A_out, 64'd7);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || A_out !== e) begin
      miscompares++;
      $display("FAIL precomp_random: out_valid=%0b A_out=%h want 1/%h", out_valid, A_out, e);
    end
    tick();
  endtask
`endif

  initial begin
    int r;
    int inv;
    qinv_tb = calc_qinv();
    r = 1;
    for (int i = 0; i < 64; i++) r = (r * 2) % int'(QM);
    inv = 1;
    for (int i = 0; i < int'(QM) - 2; i++) inv = (inv * r) % int'(QM);
    negr = (int'(QM) - inv) % int'(QM);

    test_reset();
    test_identity();
    test_qinv();
    test_back_to_back();
    test_backpressure();
    test_random_flow();
    test_reset_midflight();
`ifdef PLANTARD_PREMUL_PRECOMP_EN
    test_precomp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
